// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell codes, colours and drawing geometry for the tic-tac-toe pixel generator
package ttt_pkg;
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] X     = 2'b01;
    localparam logic [1:0] O     = 2'b10;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] WHITE   = 3'b111;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;

    localparam int GRID_HW = 2;
    localparam int CUR_LO  = 4;
    localparam int CUR_HI  = 7;
    localparam int GLYPH_M = 16;
    localparam int STROKE  = 3;
    localparam int R_IN    = 36;
    localparam int R_OUT   = 44;
    localparam int R_IN2   = R_IN * R_IN;
    localparam int R_OUT2  = R_OUT * R_OUT;

    function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/ttt_pixel_gen_if.sv
// ttt_pixel_gen_if: sync-stage timing, game state in; delayed syncs and colour out
// master drives p_tick/pixel_x/pixel_y/video_on/hsync_in/vsync_in/board/cursor/game_over
// slave drives hsync/vsync/rgb
interface ttt_pixel_gen_if;
    logic        p_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic        game_over;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, board, cursor, game_over,
        input  hsync, vsync, rgb
    );
    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, board, cursor, game_over,
        output hsync, vsync, rgb
    );
endinterface

// File: rtl/ttt_cell_glyph.sv
// ttt_cell_glyph: X/O glyph hit test for an in-cell offset (ox, oy)
// in: ox, oy (0..CELL-1), code (cell code); out: x_on, o_on
module ttt_cell_glyph
    import ttt_pkg::*;
#(
    parameter int CELL = 120
) (
    input  logic [6:0] ox,
    input  logic [6:0] oy,
    input  logic [1:0] code,
    output logic       x_on,
    output logic       o_on
);
    localparam logic [6:0] C  = 7'(CELL / 2);
    localparam logic [6:0] LO = 7'(GLYPH_M);
    localparam logic [6:0] HI = 7'(CELL - 1 - GLYPH_M);
    localparam logic [7:0] AD = 8'(CELL - 1);
    logic [6:0]  ax, ay, dd;
    logic [7:0]  s, ds;
    logic [12:0] d2;
    always_comb begin
        ax = ox >= C ? ox - C : C - ox;
        ay = oy >= C ? oy - C : C - oy;
        d2 = 13'(ax) * 13'(ax) + 13'(ay) * 13'(ay);
        dd = ox >= oy ? ox - oy : oy - ox;
        s  = {1'b0, ox} + {1'b0, oy};
        ds = s >= AD ? s - AD : AD - s;
        x_on = code == X && ox >= LO && ox <= HI && oy >= LO && oy <= HI
               && (dd <= 7'(STROKE) || ds <= 8'(STROKE));
        o_on = code == O && d2 >= 13'(R_IN2) && d2 <= 13'(R_OUT2);
    end
endmodule

// File: rtl/ttt_pixel_gen.sv
// ttt_pixel_gen: draws board, glyphs and blinking cursor with a 2-p_tick pipeline
// in: clk, reset, bus.{p_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, board, cursor, game_over}
// out: bus.{hsync, vsync, rgb}
module ttt_pixel_gen
    import ttt_pkg::*;
#(
    parameter int BOARD_X0     = 140,
    parameter int BOARD_Y0     = 60,
    parameter int CELL         = 120,
    parameter int BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          reset,
    ttt_pixel_gen_if.slave bus
);
    logic [17:0] sh_board;
    logic [3:0]  sh_cursor;
    logic        sh_over;
    logic [5:0]  fcnt;
    logic        blink_on;
    logic [9:0]  nx, ny, lx, ly;
    logic        in_b, vo1, hs1, vs1;
    logic [1:0]  cx, cy, code;
    logic [6:0]  ox, oy;
    logic [3:0]  idx;
    logic [4:0]  bi;
    logic        grid, cur, x_on, o_on;
    logic [2:0]  rgb_n;

    function automatic logic on_line(input logic [9:0] v);
        return in_rng(v, 10'(CELL - GRID_HW), 10'(CELL + GRID_HW - 1))
            || in_rng(v, 10'(2 * CELL - GRID_HW), 10'(2 * CELL + GRID_HW - 1));
    endfunction

    function automatic logic band(input logic [6:0] v);
        return in_rng({3'b0, v}, 10'(CUR_LO), 10'(CUR_HI))
            || in_rng({3'b0, v}, 10'(CELL - 1 - CUR_HI), 10'(CELL - 1 - CUR_LO));
    endfunction

    assign nx = bus.pixel_x - 10'(BOARD_X0);
    assign ny = bus.pixel_y - 10'(BOARD_Y0);

    always_ff @(posedge clk) begin
        if (reset) begin
            {lx, ly, in_b, vo1, hs1, vs1} <= '0;
            {bus.rgb, bus.hsync, bus.vsync} <= '0;
            sh_board  <= '0;
            sh_cursor <= 4'hf;
            sh_over   <= 1'b0;
            fcnt      <= '0;
            blink_on  <= 1'b0;
        end else if (bus.p_tick) begin
            lx        <= nx;
            ly        <= ny;
            in_b      <= nx < 10'(3 * CELL) && ny < 10'(3 * CELL);
            vo1       <= bus.video_on;
            hs1       <= bus.hsync_in;
            vs1       <= bus.vsync_in;
            bus.rgb   <= rgb_n;
            bus.hsync <= hs1;
            bus.vsync <= vs1;
            // first blanked line after the visible area: snapshot game state for the next frame
            if (bus.pixel_x == 10'd0 && bus.pixel_y == 10'd480) begin
                sh_board  <= bus.board;
                sh_cursor <= bus.cursor;
                sh_over   <= bus.game_over;
                fcnt      <= fcnt == 6'(BLINK_FRAMES - 1) ? 6'd0 : fcnt + 6'd1;
                if (fcnt == 6'(BLINK_FRAMES - 1))
                    blink_on <= ~blink_on;
            end
        end
    end

    always_comb begin
        cx   = lx < 10'(CELL) ? 2'd0 : lx < 10'(2 * CELL) ? 2'd1 : 2'd2;
        cy   = ly < 10'(CELL) ? 2'd0 : ly < 10'(2 * CELL) ? 2'd1 : 2'd2;
        ox   = 7'(lx - (cx == 2'd0 ? 10'd0 : cx == 2'd1 ? 10'(CELL) : 10'(2 * CELL)));
        oy   = 7'(ly - (cy == 2'd0 ? 10'd0 : cy == 2'd1 ? 10'(CELL) : 10'(2 * CELL)));
        idx  = 4'(3 * cy + cx);
        bi   = {idx, 1'b0};
        code = sh_board[bi +: 2];
        grid = in_b && (on_line(lx) || on_line(ly));
        cur  = in_b && blink_on && !sh_over && sh_cursor == idx && (band(ox) || band(oy));
        rgb_n = !vo1         ? BLACK
              : grid         ? (sh_over && blink_on ? MAGENTA : WHITE)
              : cur          ? YELLOW
              : in_b && x_on ? RED
              : in_b && o_on ? BLUE
              : in_b         ? BLACK
              :                GREEN;
    end

    ttt_cell_glyph #(.CELL(CELL)) u_glyph (
        .ox   (ox),
        .oy   (oy),
        .code (code),
        .x_on (x_on),
        .o_on (o_on)
    );
endmodule

// File: tb/tb_ttt_pixel_gen.sv
// tb_ttt_pixel_gen: directed checks of colour, sync delay, frame latch and blink
module tb_ttt_pixel_gen;
    import ttt_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   nfr = 0;

    ttt_pixel_gen_if bus();

    ttt_pixel_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick(input int x, input int y, input logic vo, input logic hs, input logic vs);
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.video_on = vo;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.p_tick   = 1'b1;
        @(posedge clk);
        #1 bus.p_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic px(input string tag, input int x, input int y, input logic vo, input logic [2:0] exp);
        tick(x, y, vo, 1'b0, 1'b0);
        tick(x, y, vo, 1'b0, 1'b0);
        chk(tag, bus.rgb, exp);
    endtask

    task automatic frame();
        tick(0, 480, 1'b0, 1'b0, 1'b0);
        nfr++;
    endtask

    function automatic logic blink();
        return (nfr / 30) % 2 == 1;
    endfunction

    initial begin
        bus.p_tick = 1'b0;
        bus.pixel_x = '0;
        bus.pixel_y = '0;
        bus.video_on = 1'b0;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        bus.board = '0;
        bus.cursor = 4'd0;
        bus.game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick(0, 0, 1'b1, 1'b1, 1'b1);
        chk("rst_rgb", bus.rgb, BLACK);
        chk("rst_hs", 3'(bus.hsync), 3'd0);
        chk("rst_vs", 3'(bus.vsync), 3'd0);
        reset = 1'b0;

        tick(0, 0, 1'b1, 1'b1, 1'b1);
        chk("rel1_rgb", bus.rgb, BLACK);
        chk("rel1_hs", 3'(bus.hsync), 3'd0);
        tick(0, 0, 1'b1, 1'b0, 1'b0);
        chk("rel2_rgb", bus.rgb, GREEN);
        chk("rel2_hs", 3'(bus.hsync), 3'd1);
        chk("rel2_vs", 3'(bus.vsync), 3'd1);
        tick(0, 0, 1'b1, 1'b0, 1'b0);
        chk("rel3_hs", 3'(bus.hsync), 3'd0);
        chk("rel3_vs", 3'(bus.vsync), 3'd0);

        bus.board = 18'h30201;
        px("pre_latch", 200, 120, 1'b1, BLACK);
        frame();
        px("x_centre", 200, 120, 1'b1, RED);
        px("x_stroke3", 200, 123, 1'b1, RED);
        px("x_stroke4", 200, 124, 1'b1, BLACK);
        px("x_margin", 156, 76, 1'b1, RED);
        px("x_margin_out", 155, 75, 1'b1, BLACK);
        px("x_anti", 156, 163, 1'b1, RED);
        px("o_ring", 320, 200, 1'b1, BLUE);
        px("o_d2000", 340, 200, 1'b1, BLACK);
        px("o_centre", 320, 240, 1'b1, BLACK);
        px("o_d400", 300, 240, 1'b1, BLACK);
        px("o_d800", 340, 220, 1'b1, BLACK);
        px("o_r36", 356, 240, 1'b1, BLUE);
        px("o_r44", 364, 240, 1'b1, BLUE);
        px("o_r35", 355, 240, 1'b1, BLACK);
        px("o_r45", 365, 240, 1'b1, BLACK);
        px("code11_c", 440, 360, 1'b1, BLACK);
        px("code11_ring", 440, 320, 1'b1, BLACK);
        px("grid119", 259, 100, 1'b1, WHITE);
        px("grid118", 258, 100, 1'b1, WHITE);
        px("grid117", 257, 100, 1'b1, BLACK);
        px("grid121", 261, 100, 1'b1, WHITE);
        px("grid122", 262, 100, 1'b1, BLACK);
        px("grid_row", 300, 179, 1'b1, WHITE);
        px("x500", 500, 100, 1'b1, GREEN);
        px("x499", 499, 100, 1'b1, BLACK);
        px("x139", 139, 100, 1'b1, GREEN);
        px("y59", 200, 59, 1'b1, GREEN);
        px("y419", 200, 419, 1'b1, BLACK);
        px("y420", 200, 420, 1'b1, GREEN);
        px("vo_off", 700, 100, 1'b0, BLACK);
        px("vo_off_grid", 259, 100, 1'b0, BLACK);

        px("lat0", 200, 120, 1'b1, RED);
        tick(259, 100, 1'b1, 1'b0, 1'b0);
        chk("lat1", bus.rgb, RED);
        tick(259, 100, 1'b1, 1'b0, 1'b0);
        chk("lat2", bus.rgb, WHITE);
        bus.pixel_x = 10'd500;
        bus.video_on = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("hold", bus.rgb, WHITE);

        bus.cursor = 4'd4;
        px("cur_unlatched", 265, 240, 1'b1, BLACK);
        while (nfr < 45) begin
            frame();
            px("cur_blink", 265, 240, 1'b1, blink() ? YELLOW : BLACK);
        end
        bus.cursor = 4'd0;
        px("cur_mid_old", 265, 240, 1'b1, YELLOW);
        px("cur_mid_new", 145, 120, 1'b1, BLACK);
        frame();
        px("cur_moved_old", 265, 240, 1'b1, BLACK);
        px("cur_moved_new", 145, 120, 1'b1, YELLOW);
        bus.cursor = 4'd4;
        while (nfr < 61) begin
            frame();
            px("cur_blink2", 265, 240, 1'b1, blink() ? YELLOW : BLACK);
        end

        bus.game_over = 1'b1;
        while (nfr < 95) begin
            frame();
            px("over_grid", 259, 100, 1'b1, blink() ? MAGENTA : WHITE);
            px("over_cursor", 265, 240, 1'b1, BLACK);
        end

        tick(259, 100, 1'b1, 1'b1, 1'b1);
        tick(259, 100, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_rgb", bus.rgb, MAGENTA);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rgb", bus.rgb, BLACK);
        chk("mid_rst_hs", 3'(bus.hsync), 3'd0);
        chk("mid_rst_vs", 3'(bus.vsync), 3'd0);
        chk("mid_rst_blink", 3'(dut.blink_on), 3'd0);
        reset = 1'b0;
        tick(259, 100, 1'b1, 1'b0, 1'b0);
        chk("mid_rel1", bus.rgb, BLACK);
        tick(259, 100, 1'b1, 1'b0, 1'b0);
        chk("mid_rel2", bus.rgb, WHITE);
        px("mid_board_clr", 200, 120, 1'b1, BLACK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
